// File: rtl/axi4_mix_pkg.sv
// Shared definitions for the AXI4 write interconnect control plane and datapath:
// AW FSM states, round-robin pick helper and BID index field placement.
package axi4_mix_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } aw_state_e;

  // The slaver index sits at BID[BID_IDX_LSB +: NSIZE]; lower bits carry the slaver's own ID.
  localparam int BID_IDX_LSB = 4;

  // First set bit of valid at or after ptr, wrapping within num ports (num <= 16).
  function automatic logic [3:0] rr_pick(input logic [15:0] valid, input logic [3:0] ptr,
                                         input int num);
    logic [3:0] pick;
    logic       found;
    int         idx;
    pick  = 4'd0;
    found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      idx = (int'(ptr) + i) % num;
      if ((i < num) && !found && valid[idx]) begin
        pick  = 4'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/axi4_route_fifo.sv
// In-order route queue: holds the slaver index of each granted AW burst until
// its W data completes. Head is read combinationally.
module axi4_route_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign count     = count_r;
  assign head      = mem_r[rd_ptr_r];

  // Storage, pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/axi4_wr_mix_scheduler.sv
// Control plane for the NUM-to-1 AXI4 write interconnect: round-robin AW grant,
// in-order W steering from the route queue, and BID-indexed B return.
module axi4_wr_mix_scheduler
  import axi4_mix_pkg::*;
#(
  parameter  int NUM   = 8,
  parameter  int DEPTH = 4,
  localparam int NSIZE = $clog2(NUM)
) (
  input  logic             axi_aclk,
  input  logic             axi_aresetn,
  input  logic [NUM-1:0]   s_aw_valid,
  output logic [NUM-1:0]   s_aw_ready,
  output logic             m_aw_valid,
  input  logic             m_aw_ready,
  output logic [NSIZE-1:0] aw_sel,
  input  logic [NUM-1:0]   s_w_valid,
  output logic [NUM-1:0]   s_w_ready,
  output logic             m_w_valid,
  input  logic             m_w_ready,
  input  logic             m_w_last,
  output logic [NSIZE-1:0] w_sel,
  input  logic             m_b_valid,
  output logic             m_b_ready,
  input  logic [NSIZE-1:0] b_idx,
  output logic [NUM-1:0]   s_b_valid,
  input  logic [NUM-1:0]   s_b_ready,
  output logic             b_err
);

  aw_state_e              state_r;
  aw_state_e              state_nxt;
  logic [NSIZE-1:0]       grant_r;
  logic [NSIZE-1:0]       grant_nxt;
  logic [NSIZE-1:0]       rr_ptr_r;
  logic [NSIZE-1:0]       rr_ptr_nxt;
  logic [3:0]             pick_s;
  logic                   q_push_s;
  logic                   q_pop_s;
  logic [NSIZE-1:0]       q_head_s;
  logic [$clog2(DEPTH):0] q_count_s;
  logic                   q_full_s;
  logic                   q_empty_s;
  logic                   b_idx_ok_s;
  logic                   b_err_r;

  assign pick_s     = rr_pick(16'(s_aw_valid), 4'(rr_ptr_r), NUM);
  assign aw_sel     = grant_r;
  assign q_push_s   = m_aw_valid && m_aw_ready && !q_full_s;
  assign q_pop_s    = m_w_valid && m_w_ready && m_w_last;
  assign b_idx_ok_s = (int'(b_idx) < NUM);
  assign b_err      = b_err_r;

  // AW FSM state, locked grant and round-robin pointer.
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      state_r  <= IDLE;
      grant_r  <= {NSIZE{1'b0}};
      rr_ptr_r <= {NSIZE{1'b0}};
    end else begin
      state_r  <= state_nxt;
      grant_r  <= grant_nxt;
      rr_ptr_r <= rr_ptr_nxt;
    end
  end

  // AW next-state and handshake steering; the grant stays fixed for the whole ISSUE phase.
  always_comb begin
    state_nxt  = state_r;
    grant_nxt  = grant_r;
    rr_ptr_nxt = rr_ptr_r;
    m_aw_valid = 1'b0;
    s_aw_ready = {NUM{1'b0}};
    case (state_r)
      IDLE: begin
        if ((|s_aw_valid) && (int'(q_count_s) < DEPTH)) begin
          grant_nxt = pick_s[NSIZE-1:0];
          state_nxt = ISSUE;
        end else begin
          state_nxt = IDLE;
        end
      end
      ISSUE: begin
        m_aw_valid          = 1'b1;
        s_aw_ready[grant_r] = m_aw_ready;
        if (m_aw_ready) begin
          rr_ptr_nxt = (int'(grant_r) == NUM - 1) ? {NSIZE{1'b0}} : grant_r + NSIZE'(1);
          state_nxt  = IDLE;
        end else begin
          state_nxt  = ISSUE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  axi4_route_fifo #(
    .WIDTH (NSIZE),
    .DEPTH (DEPTH)
  ) u_route_fifo (
    .clk       (axi_aclk),
    .rst_n     (axi_aresetn),
    .push      (q_push_s),
    .push_data (grant_r),
    .pop       (q_pop_s),
    .head      (q_head_s),
    .count     (q_count_s),
    .full      (q_full_s),
    .empty     (q_empty_s)
  );

  // W steering from the queue head; an empty queue stalls every slaver.
  always_comb begin
    w_sel     = {NSIZE{1'b0}};
    m_w_valid = 1'b0;
    s_w_ready = {NUM{1'b0}};
    if (!q_empty_s) begin
      w_sel               = q_head_s;
      m_w_valid           = s_w_valid[q_head_s];
      s_w_ready[q_head_s] = m_w_ready;
    end else begin
      w_sel     = {NSIZE{1'b0}};
      m_w_valid = 1'b0;
    end
  end

  // B return by BID index; out-of-range indices are accepted and dropped.
  always_comb begin
    s_b_valid = {NUM{1'b0}};
    m_b_ready = 1'b1;
    if (b_idx_ok_s) begin
      s_b_valid[b_idx] = m_b_valid;
      m_b_ready        = s_b_ready[b_idx];
    end else begin
      m_b_ready = 1'b1;
    end
  end

  // One-cycle flag per sunk B response.
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      b_err_r <= 1'b0;
    end else begin
      b_err_r <= m_b_valid && !b_idx_ok_s;
    end
  end

endmodule

// File: tb/tb_axi4_wr_mix_scheduler.sv
// Directed bench for axi4_wr_mix_scheduler: NUM=8/DEPTH=4 main instance plus a
// NUM=6 instance for out-of-range BID handling.
module tb_axi4_wr_mix_scheduler;

  logic       axi_aclk;
  logic       axi_aresetn;
  logic [7:0] s_aw_valid, s_aw_ready, s_w_valid, s_w_ready, s_b_valid, s_b_ready;
  logic       m_aw_valid, m_aw_ready, m_w_valid, m_w_ready, m_w_last;
  logic       m_b_valid, m_b_ready, b_err;
  logic [2:0] aw_sel, w_sel, b_idx;

  logic [5:0] s_aw_valid6, s_aw_ready6, s_w_valid6, s_w_ready6, s_b_valid6, s_b_ready6;
  logic       m_aw_valid6, m_w_valid6, m_b_valid6, m_b_ready6, b_err6;
  logic [2:0] aw_sel6, w_sel6, b_idx6;

  int checks_cnt = 0;
  int errors_cnt = 0;

  axi4_wr_mix_scheduler #(.NUM(8), .DEPTH(4)) dut (
    .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
    .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .m_aw_valid(m_aw_valid),
    .m_aw_ready(m_aw_ready), .aw_sel(aw_sel),
    .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .m_w_valid(m_w_valid),
    .m_w_ready(m_w_ready), .m_w_last(m_w_last), .w_sel(w_sel),
    .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .b_idx(b_idx),
    .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .b_err(b_err)
  );

  axi4_wr_mix_scheduler #(.NUM(6), .DEPTH(4)) dut6 (
    .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
    .s_aw_valid(s_aw_valid6), .s_aw_ready(s_aw_ready6), .m_aw_valid(m_aw_valid6),
    .m_aw_ready(1'b0), .aw_sel(aw_sel6),
    .s_w_valid(s_w_valid6), .s_w_ready(s_w_ready6), .m_w_valid(m_w_valid6),
    .m_w_ready(1'b0), .m_w_last(1'b0), .w_sel(w_sel6),
    .m_b_valid(m_b_valid6), .m_b_ready(m_b_ready6), .b_idx(b_idx6),
    .s_b_valid(s_b_valid6), .s_b_ready(s_b_ready6), .b_err(b_err6)
  );

  initial axi_aclk = 1'b0;
  always #5 axi_aclk = ~axi_aclk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge axi_aclk);
    #1;
  endtask

  task automatic clear_inputs();
    s_aw_valid = 8'h00; m_aw_ready = 1'b0;
    s_w_valid  = 8'h00; m_w_ready  = 1'b0; m_w_last = 1'b0;
    m_b_valid  = 1'b0;  b_idx      = 3'd0; s_b_ready = 8'h00;
    s_aw_valid6 = 6'h00; s_w_valid6 = 6'h00;
    m_b_valid6  = 1'b0;  b_idx6     = 3'd0; s_b_ready6 = 6'h00;
  endtask

  task automatic reset_dut();
    axi_aresetn = 1'b0;
    clear_inputs();
    step();
    step();
    axi_aresetn = 1'b1;
  endtask

  initial begin
    axi_aresetn = 1'b0;
    reset_dut();
    #1;
    check_eq("rst_m_aw_valid", 32'(m_aw_valid), 32'd0);
    check_eq("rst_s_aw_ready", 32'(s_aw_ready), 32'h00);
    check_eq("rst_aw_sel",     32'(aw_sel),     32'd0);
    check_eq("rst_m_w_valid",  32'(m_w_valid),  32'd0);
    check_eq("rst_s_w_ready",  32'(s_w_ready),  32'h00);
    check_eq("rst_w_sel",      32'(w_sel),      32'd0);
    check_eq("rst_b_err",      32'(b_err),      32'd0);

    // Round robin over slavers 0 and 2.
    s_aw_valid = 8'h05; m_aw_ready = 1'b1;
    #1 check_eq("rr_idle_first", 32'(m_aw_valid), 32'd0);
    step();
    check_eq("rr_g0_valid", 32'(m_aw_valid), 32'd1);
    check_eq("rr_g0_sel",   32'(aw_sel),     32'd0);
    check_eq("rr_g0_ready", 32'(s_aw_ready), 32'h01);
    step();
    check_eq("rr_idle_gap", 32'(m_aw_valid), 32'd0);
    check_eq("rr_head0",    32'(w_sel),      32'd0);
    step();
    check_eq("rr_g2_sel",   32'(aw_sel),     32'd2);
    check_eq("rr_g2_ready", 32'(s_aw_ready), 32'h04);
    step();
    step();
    check_eq("rr_g0b_sel",  32'(aw_sel),     32'd0);
    step();
    s_aw_valid = 8'h00;
    // Drain queue 0,2,0 with single-beat bursts.
    s_w_valid = 8'h01; m_w_ready = 1'b1; m_w_last = 1'b1;
    #1;
    check_eq("q0_w_sel",   32'(w_sel),     32'd0);
    check_eq("q0_w_valid", 32'(m_w_valid), 32'd1);
    check_eq("q0_w_ready", 32'(s_w_ready), 32'h01);
    step();
    s_w_valid = 8'h00;
    #1;
    check_eq("q1_w_sel",   32'(w_sel),     32'd2);
    check_eq("q1_w_valid", 32'(m_w_valid), 32'd0);
    check_eq("q1_w_ready", 32'(s_w_ready), 32'h04);
    s_w_valid = 8'h04;
    step();
    check_eq("q2_w_sel",   32'(w_sel),     32'd0);
    s_w_valid = 8'h01;
    step();
    check_eq("q_empty_valid", 32'(m_w_valid), 32'd0);
    check_eq("q_empty_ready", 32'(s_w_ready), 32'h00);
    s_w_valid = 8'h00; m_w_ready = 1'b0; m_w_last = 1'b0;

    // Fill the queue from slaver 3 with W held off, then free one slot.
    s_aw_valid = 8'h08; m_aw_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check_eq("fill_sel", 32'(aw_sel), 32'd3);
      step();
    end
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("full_blocked", 32'(m_aw_valid), 32'd0);
    end
    s_w_valid = 8'h08; m_w_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      m_w_last = (b == 3);
      #1;
      check_eq("burst_w_valid", 32'(m_w_valid), 32'd1);
      check_eq("burst_w_sel",   32'(w_sel),     32'd3);
      if (b == 3) check_eq("no_bypass", 32'(m_aw_valid), 32'd0);
      step();
    end
    s_w_valid = 8'h00; m_w_ready = 1'b0; m_w_last = 1'b0;
    #1 check_eq("after_pop_idle", 32'(m_aw_valid), 32'd0);
    step();
    check_eq("after_pop_issue", 32'(m_aw_valid), 32'd1);
    check_eq("after_pop_sel",   32'(aw_sel),     32'd3);
    reset_dut();

    // Slaver 1 then slaver 5: slaver 5's data waits for slaver 1's WLAST.
    s_aw_valid = 8'h22; m_aw_ready = 1'b1;
    step();
    check_eq("il_g1", 32'(aw_sel), 32'd1);
    step();
    s_aw_valid = 8'h20;
    #1 check_eq("il_head1_visible", 32'(w_sel), 32'd1);
    step();
    check_eq("il_g5", 32'(aw_sel), 32'd5);
    step();
    s_aw_valid = 8'h00; m_aw_ready = 1'b0;
    s_w_valid = 8'h22; m_w_ready = 1'b1; m_w_last = 1'b0;
    #1;
    check_eq("il_b0_ready", 32'(s_w_ready), 32'h02);
    check_eq("il_b0_sel",   32'(w_sel),     32'd1);
    step();
    m_w_last = 1'b1;
    #1 check_eq("il_b1_ready", 32'(s_w_ready), 32'h02);
    step();
    check_eq("il_sw_sel",   32'(w_sel),     32'd5);
    check_eq("il_sw_ready", 32'(s_w_ready), 32'h20);
    check_eq("il_sw_valid", 32'(m_w_valid), 32'd1);
    step();
    check_eq("il_single_pop", 32'(m_w_valid), 32'd0);
    reset_dut();

    // Grant 4 held while AWREADY is low; slaver 6 waits.
    s_aw_valid = 8'h10; m_aw_ready = 1'b0;
    step();
    s_aw_valid = 8'h50;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq("lock_sel",   32'(aw_sel),     32'd4);
      check_eq("lock_ready", 32'(s_aw_ready), 32'h00);
      if (k < 2) step();
    end
    m_aw_ready = 1'b1;
    #1 check_eq("lock_hs_ready", 32'(s_aw_ready), 32'h10);
    step();
    s_aw_valid = 8'h40;
    step();
    check_eq("lock_then_g6", 32'(aw_sel), 32'd6);
    step();
    s_aw_valid = 8'h00; m_aw_ready = 1'b0;

    // B routing, in range and out of range.
    b_idx = 3'd3; m_b_valid = 1'b1; s_b_ready = 8'h00;
    #1;
    check_eq("b3_valid",     32'(s_b_valid), 32'h08);
    check_eq("b3_ready_low", 32'(m_b_ready), 32'd0);
    s_b_ready = 8'h08;
    #1 check_eq("b3_ready_high", 32'(m_b_ready), 32'd1);
    b_idx6 = 3'd2; m_b_valid6 = 1'b1; s_b_ready6 = 6'h00;
    #1 check_eq("b6_idx2_valid", 32'(s_b_valid6), 32'h04);
    b_idx6 = 3'd7;
    #1;
    check_eq("b6_sink_ready", 32'(m_b_ready6), 32'd1);
    check_eq("b6_sink_valid", 32'(s_b_valid6), 32'h00);
    check_eq("b6_err_before", 32'(b_err6),     32'd0);
    step();
    m_b_valid6 = 1'b0; m_b_valid = 1'b0;
    #1;
    check_eq("b6_err_pulse", 32'(b_err6), 32'd1);
    check_eq("b8_no_err",    32'(b_err),  32'd0);
    step();
    check_eq("b6_err_clear", 32'(b_err6), 32'd0);
    reset_dut();

    // Reset mid-burst with two routes queued and an AW in flight.
    s_aw_valid = 8'h03; m_aw_ready = 1'b1;
    step(); step(); step(); step();
    s_aw_valid = 8'h04; m_aw_ready = 1'b0;
    s_w_valid = 8'h01; m_w_ready = 1'b1; m_w_last = 1'b0;
    #1 check_eq("mid_w_valid", 32'(m_w_valid), 32'd1);
    step();
    check_eq("mid_aw_valid", 32'(m_aw_valid), 32'd1);
    axi_aresetn = 1'b0;
    step();
    check_eq("mrst_w_valid",  32'(m_w_valid),  32'd0);
    check_eq("mrst_aw_valid", 32'(m_aw_valid), 32'd0);
    check_eq("mrst_w_ready",  32'(s_w_ready),  32'h00);
    axi_aresetn = 1'b1;
    s_aw_valid = 8'hFF; m_aw_ready = 1'b0;
    step();
    check_eq("mrst_rr_zero", 32'(aw_sel), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
